mem_bus_controller: RTL

//  Upstream master for the 4x1KB unified memory's data port (address_bus, data_bus, write_mode).

---
 rtl/mem_bus_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_controller.sv
// mem_bus_controller
//   Upstream master for the unified memory's data port. CPU load/store
//   requests are queued in a small FIFO and sequenced onto the shared
//   tri-state bus (address_bus / data_bus / write_mode). Reads account for
//   the memory's registered one-cycle latency. Exactly one response pulse
//   is returned per accepted request, in request order.
//
//   Optional feature macro: MEM_ALIGN_CHECK_EN
//     defined   : requests with addr[0]=1 are rejected with resp_err=1 and
//                 never reach the bus.
//     undefined : resp_err is tied 0 and odd addresses are issued as-is.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready = FIFO not full)
//   req_we, req_addr, req_wdata  request payload (1 = store)
//   resp_valid                   one-cycle response pulse
//   resp_we, resp_rdata          echoed we, load data (0 for stores)
//   resp_err                     misaligned-request flag
//   busy                         FIFO non-empty or FSM not idle
//   address_bus, data_bus        memory bus; data_bus driven only on writes
//   write_mode                   memory write strobe, also the bus drive enable
module mem_bus_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 12,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic          resp_we,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          busy,
  output logic [AW-1:0] address_bus,
  inout  wire  [DW-1:0] data_bus,
  output logic          write_mode
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR
`ifdef MEM_ALIGN_CHECK_EN
    , ERR
`endif
  } state_t;

  state_t state, state_nxt, head_state;

  logic          fifo_we    [FIFO_DEPTH];
  logic [AW-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DW-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, push, pop;

  logic          head_we, head_bad;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  logic [DW-1:0] wdata_q, wdata_nxt, rdata_nxt;
  logic [AW-1:0] addr_nxt;
  logic          wm_nxt, rv_nxt, rwe_nxt;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_we, err_we_nxt, rerr_nxt;
`else
  assign resp_err = 1'b0;
`endif

  // ---------------- request FIFO ----------------
  assign empty     = (count == '0);
  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid && req_ready;

  assign head_we    = fifo_we[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];

`ifdef MEM_ALIGN_CHECK_EN
  assign head_bad = head_addr[0];
`else
  assign head_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  assign busy = !empty || (state != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    head_state = head_we ? WR : RD_ADDR;
`ifdef MEM_ALIGN_CHECK_EN
    if (head_bad) head_state = ERR;
`endif
  end

  // Every state except RD_ADDR finishes its work this cycle, so the next
  // request is popped straight away without passing through IDLE.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (state == RD_ADDR) begin
      state_nxt = RD_CAP;
    end else if (!empty) begin
      pop       = 1'b1;
      state_nxt = head_state;
    end else begin
      state_nxt = IDLE;
    end
  end

  // Bus and response outputs are registered; this computes their next values.
  always_comb begin
    addr_nxt  = address_bus;
    wm_nxt    = 1'b0;
    wdata_nxt = wdata_q;
    rv_nxt    = 1'b0;
    rwe_nxt   = resp_we;
    rdata_nxt = resp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    rerr_nxt   = 1'b0;
    err_we_nxt = err_we;
`endif
    case (state)
      RD_CAP: begin
        rv_nxt    = 1'b1;
        rwe_nxt   = 1'b0;
        rdata_nxt = data_bus;
      end
      WR: begin
        rv_nxt    = 1'b1;
        rwe_nxt   = 1'b1;
        rdata_nxt = '0;
      end
`ifdef MEM_ALIGN_CHECK_EN
      ERR: begin
        rv_nxt    = 1'b1;
        rwe_nxt   = err_we;
        rdata_nxt = '0;
        rerr_nxt  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (pop) begin
      if (!head_bad) begin
        addr_nxt  = head_addr;
        wm_nxt    = head_we;
        wdata_nxt = head_wdata;
      end
`ifdef MEM_ALIGN_CHECK_EN
      err_we_nxt = head_we;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_bus <= '0;
      write_mode  <= 1'b0;
      wdata_q     <= '0;
      resp_valid  <= 1'b0;
      resp_we     <= 1'b0;
      resp_rdata  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      resp_err    <= 1'b0;
      err_we      <= 1'b0;
`endif
    end else begin
      address_bus <= addr_nxt;
      write_mode  <= wm_nxt;
      wdata_q     <= wdata_nxt;
      resp_valid  <= rv_nxt;
      resp_we     <= rwe_nxt;
      resp_rdata  <= rdata_nxt;
`ifdef MEM_ALIGN_CHECK_EN
      resp_err    <= rerr_nxt;
      err_we      <= err_we_nxt;
`endif
    end
  end

  // write_mode doubles as the drive enable, so the bus is released in every
  // non-write cycle without a separate turnaround.
  assign data_bus = write_mode ? wdata_q : {DW{1'bz}};

endmodule
